instr_issue_queue: RTL and testbench

- Parametrised instruction front end for the accelerator core.
- Buffers host-pushed instructions in a circular FIFO and issues them one at a time to Control_Unit.
- Waits for the controller's completion pulse before issuing the next instruction.
- Drops NOP and illegal opcodes without issuing them, and keeps status counters.

---
 rtl/instr_issue_queue.sv | 138 +++++++++++++
 tb/tb_instr_issue_queue.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - Instruction FIFO with single-outstanding issue FSM to Control_Unit
// Optional ISSUE_PERF_CNT_EN adds stall_cnt/starve_cnt performance counters.
module instr_issue_queue #(
    parameter int INSTR_WIDTH  = 29,
    parameter int OPCODE_WIDTH = 3,
    parameter int DEPTH        = 8,
    parameter int MAX_OPCODE   = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       CLK,
    input  logic                       ASYNC_RST,
    input  logic                       SYNC_RST,
    input  logic                       EN,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [INSTR_WIDTH-1:0]     push_data,
    input  logic                       cu_done,
    output logic [INSTR_WIDTH-1:0]     instruction,
    output logic                       instr_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       illegal_err,
    output logic [CNT_WIDTH-1:0]       issued_cnt,
`ifdef ISSUE_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]       stall_cnt,
    output logic [CNT_WIDTH-1:0]       starve_cnt,
`endif
    output logic [CNT_WIDTH-1:0]       nop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [INSTR_WIDTH-1:0]  mem [DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic [1:0]              state;
    logic                    empty;
    logic                    do_push;
    logic                    do_pop;
    logic [INSTR_WIDTH-1:0]  head;
    logic [OPCODE_WIDTH-1:0] head_op;
    logic                    op_nop;
    logic                    op_illegal;

    assign fill_level  = wr_ptr - rd_ptr;
    assign empty       = (fill_level == '0);
    assign push_ready  = (fill_level < FULL_LVL);
    assign do_push     = push_valid && push_ready && !flush;
    // Flush wins over a dispatch in the same cycle, so nothing is consumed from a queue being emptied.
    assign do_pop      = (state == IDLE) && EN && !empty && !flush;
    assign head        = mem[rd_ptr[AW-1:0]];
    assign head_op     = head[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign op_nop      = (head_op == '0);
    assign op_illegal  = (32'(head_op) > MAX_OPCODE);
    assign instr_valid = (state == ISSUE);
    assign busy        = !empty || (state != IDLE);

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (SYNC_RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state       <= IDLE;
            instruction <= '0;
            illegal_err <= 1'b0;
            issued_cnt  <= '0;
            nop_cnt     <= '0;
        end else if (SYNC_RST) begin
            state       <= IDLE;
            instruction <= '0;
            illegal_err <= 1'b0;
            issued_cnt  <= '0;
            nop_cnt     <= '0;
        end else if (EN) begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        if (op_nop) begin
                            nop_cnt <= nop_cnt + CNT_WIDTH'(1);
                        end else if (op_illegal) begin
                            illegal_err <= 1'b1;
                        end else begin
                            instruction <= head;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (cu_done) begin
                        state       <= IDLE;
                        instruction <= '0;
                        issued_cnt  <= issued_cnt + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            stall_cnt  <= '0;
            starve_cnt <= '0;
        end else if (SYNC_RST) begin
            stall_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            if (state == WAIT_DONE)               stall_cnt  <= stall_cnt + CNT_WIDTH'(1);
            if ((state == IDLE) && EN && empty)   starve_cnt <= starve_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - Self-checking bench for instr_issue_queue
module tb_instr_issue_queue;
    localparam int W = 29;
    localparam int CW = 16;
    localparam int FW = 4;

    logic          CLK = 1'b0;
    logic          ASYNC_RST = 1'b0;
    logic          SYNC_RST = 1'b0;
    logic          EN = 1'b0;
    logic          flush = 1'b0;
    logic          push_valid = 1'b0;
    logic          cu_done = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic          push_ready;
    logic          instr_valid;
    logic          busy;
    logic          illegal_err;
    logic [W-1:0]  instruction;
    logic [FW-1:0] fill_level;
    logic [CW-1:0] issued_cnt;
    logic [CW-1:0] nop_cnt;
`ifdef ISSUE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] starve_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    instr_issue_queue dut (
        .CLK(CLK),
        .ASYNC_RST(ASYNC_RST),
        .SYNC_RST(SYNC_RST),
        .EN(EN),
        .flush(flush),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_data(push_data),
        .cu_done(cu_done),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .busy(busy),
        .fill_level(fill_level),
        .illegal_err(illegal_err),
        .issued_cnt(issued_cnt),
`ifdef ISSUE_PERF_CNT_EN
        .stall_cnt(stall_cnt),
        .starve_cnt(starve_cnt),
`endif
        .nop_cnt(nop_cnt)
    );

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b0; flush = 1'b0;
        push_valid = 1'b0; cu_done = 1'b0; push_data = '0;
        tick();
        tick();
        ASYNC_RST = 1'b1;
    endtask

    task automatic push_one(input logic [W-1:0] d);
        push_valid = 1'b1;
        push_data = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (instruction !== '0) begin fails++; $display("FAIL reset_instruction: got %h want 0", instruction); end
        tests++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_valid_busy: got %b%b want 00", instr_valid, busy); end
        tests++; if (fill_level !== 4'd0 || push_ready !== 1'b1) begin fails++; $display("FAIL reset_fifo: got fill=%0d ready=%b want 0/1", fill_level, push_ready); end
        tests++; if (illegal_err !== 1'b0 || issued_cnt !== '0 || nop_cnt !== '0) begin fails++; $display("FAIL reset_status: got err=%b iss=%0d nop=%0d want 0", illegal_err, issued_cnt, nop_cnt); end
    endtask

    task automatic test_single_issue();
        logic [W-1:0] w;
        w = {3'd1, 8'h23, 10'h020, 4'd10, 4'd12};
        EN = 1'b1;
        push_one(w);
        tests++; if (fill_level !== 4'd1 || instr_valid !== 1'b0) begin fails++; $display("FAIL single_after_push: got fill=%0d valid=%b want 1/0", fill_level, instr_valid); end
        tick();
        tests++; if (instr_valid !== 1'b1 || instruction !== w) begin fails++; $display("FAIL single_latency: got valid=%b instr=%h want 1/%h", instr_valid, instruction, w); end
        tick();
        tick();
        tick();
        tests++; if (instr_valid !== 1'b0 || instruction !== w || busy !== 1'b1) begin fails++; $display("FAIL single_hold: got valid=%b instr=%h busy=%b want 0/%h/1", instr_valid, instruction, busy, w); end
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        tests++; if (issued_cnt !== 16'd1 || instruction !== '0 || busy !== 1'b0) begin fails++; $display("FAIL single_done: got iss=%0d instr=%h busy=%b want 1/0/0", issued_cnt, instruction, busy); end
    endtask

    task automatic test_fill_wrap();
        logic [W-1:0] exp_e [8];
        logic [2:0] op;
        bit ok;
        EN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            op = 3'(1 + i % 5);
            exp_e[i] = {op, 26'($urandom)};
            push_one(exp_e[i]);
        end
        tests++; if (fill_level !== 4'd8 || push_ready !== 1'b0) begin fails++; $display("FAIL fill_full: got fill=%0d ready=%b want 8/0", fill_level, push_ready); end
        tests++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL fill_en_hold: got valid=%b busy=%b want 0/1", instr_valid, busy); end
        push_one({3'd2, 26'h3ffffff});
        tests++; if (fill_level !== 4'd8) begin fails++; $display("FAIL fill_refuse9: got fill=%0d want 8", fill_level); end
        EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_valid(ok);
            tests++; if (!ok || instruction !== exp_e[i]) begin fails++; $display("FAIL fill_order%0d: got valid=%b instr=%h want %h", i, ok, instruction, exp_e[i]); end
            tick();
            tick();
            cu_done = 1'b1;
            tick();
            cu_done = 1'b0;
        end
        tests++; if (fill_level !== 4'd0 || issued_cnt !== 16'd9 || busy !== 1'b0) begin fails++; $display("FAIL fill_drain: got fill=%0d iss=%0d busy=%b want 0/9/0", fill_level, issued_cnt, busy); end
    endtask

    task automatic test_drop();
        logic [W-1:0] ld;
        bit ok;
        int extra;
        ld = {3'd4, 20'd0, 6'b000110};
        do_reset();
        EN = 1'b1;
        push_one({3'd0, 26'h0000abc});
        push_one({3'd0, 26'h1555555});
        push_one({3'd7, 26'h0012345});
        push_one(ld);
        wait_valid(ok);
        tests++; if (!ok || instruction !== ld) begin fails++; $display("FAIL drop_load: got valid=%b instr=%h want %h", ok, instruction, ld); end
        tick();
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (instr_valid) extra++;
            tick();
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL drop_extra_issue: got %0d want 0", extra); end
        tests++; if (nop_cnt !== 16'd2 || illegal_err !== 1'b1 || issued_cnt !== 16'd1) begin fails++; $display("FAIL drop_status: got nop=%0d err=%b iss=%0d want 2/1/1", nop_cnt, illegal_err, issued_cnt); end
    endtask

    task automatic test_flush();
        logic [W-1:0] a;
        bit ok;
        int extra;
        a = {3'd2, 26'h1234567};
        do_reset();
        EN = 1'b1;
        push_one(a);
        wait_valid(ok);
        tick();
        for (int i = 0; i < 4; i++) push_one({3'd3, 26'($urandom)});
        tests++; if (!ok || fill_level !== 4'd4) begin fails++; $display("FAIL flush_queued: got valid=%b fill=%0d want 1/4", ok, fill_level); end
        flush = 1'b1;
        push_valid = 1'b1;
        push_data = {3'd5, 26'h0};
        tick();
        flush = 1'b0;
        push_valid = 1'b0;
        tests++; if (fill_level !== 4'd0 || instruction !== a || busy !== 1'b1) begin fails++; $display("FAIL flush_effect: got fill=%0d instr=%h busy=%b want 0/%h/1", fill_level, instruction, busy, a); end
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            if (instr_valid) extra++;
            tick();
        end
        tests++; if (busy !== 1'b0 || instruction !== '0 || issued_cnt !== 16'd1 || extra != 0) begin fails++; $display("FAIL flush_done: got busy=%b instr=%h iss=%0d extra=%0d want 0/0/1/0", busy, instruction, issued_cnt, extra); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] a;
        logic [W-1:0] c;
        bit ok;
        a = {3'd1, 26'h0aaaaaa};
        c = {3'd5, 26'h0555555};
        do_reset();
        EN = 1'b1;
        push_one({3'd0, 26'h0});
        push_one(a);
        wait_valid(ok);
        tick();
        push_one({3'd2, 26'h00000ff});
        tests++; if (!ok || instruction !== a || fill_level !== 4'd1 || nop_cnt !== 16'd1) begin fails++; $display("FAIL arst_setup: got instr=%h fill=%0d nop=%0d want %h/1/1", instruction, fill_level, nop_cnt, a); end
        #1 ASYNC_RST = 1'b0;
        #1;
        tests++; if (instruction !== '0 || instr_valid !== 1'b0 || busy !== 1'b0 || fill_level !== 4'd0 || push_ready !== 1'b1 || nop_cnt !== '0 || issued_cnt !== '0) begin fails++; $display("FAIL arst_immediate: got instr=%h valid=%b busy=%b fill=%0d nop=%0d want all reset", instruction, instr_valid, busy, fill_level, nop_cnt); end
        #1 ASYNC_RST = 1'b1;
        @(negedge CLK);
        push_one(c);
        wait_valid(ok);
        tests++; if (!ok || instruction !== c) begin fails++; $display("FAIL arst_recover: got valid=%b instr=%h want %h", ok, instruction, c); end
        tick();
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        tests++; if (issued_cnt !== 16'd1 || busy !== 1'b0) begin fails++; $display("FAIL arst_after: got iss=%0d busy=%b want 1/0", issued_cnt, busy); end
    endtask

    task automatic test_idle_done_full_pop();
        logic [W-1:0] first;
        bit ok;
        do_reset();
        EN = 1'b1;
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        tests++; if (busy !== 1'b0 || issued_cnt !== '0 || instruction !== '0 || instr_valid !== 1'b0) begin fails++; $display("FAIL idle_done: got busy=%b iss=%0d instr=%h want 0/0/0", busy, issued_cnt, instruction); end
        EN = 1'b0;
        first = {3'd3, 26'h0badcaf};
        push_one(first);
        for (int i = 1; i < 8; i++) push_one({3'd4, 26'($urandom)});
        EN = 1'b1;
        push_valid = 1'b1;
        push_data = {3'd1, 26'h0};
        tick();
        push_valid = 1'b0;
        tests++; if (fill_level !== 4'd7 || instr_valid !== 1'b1 || instruction !== first) begin fails++; $display("FAIL full_pop_push: got fill=%0d valid=%b instr=%h want 7/1/%h", fill_level, instr_valid, instruction, first); end
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        tests++; if (issued_cnt !== '0 || instruction !== first || busy !== 1'b1) begin fails++; $display("FAIL issue_done_ignored: got iss=%0d instr=%h want 0/%h", issued_cnt, instruction, first); end
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        wait_valid(ok);
        EN = 1'b0;
        tick();
        tick();
        tests++; if (!ok || instr_valid !== 1'b1) begin fails++; $display("FAIL en_freeze_issue: got valid=%b want 1", instr_valid); end
        EN = 1'b1;
        tick();
        tests++; if (instr_valid !== 1'b0 || issued_cnt !== 16'd1) begin fails++; $display("FAIL en_resume: got valid=%b iss=%0d want 0/1", instr_valid, issued_cnt); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] d;
        logic [2:0] op;
        int exp_nop;
        int exp_issued;
        int cnt;
        bit exp_err;
        bit inflight;
        bit drained;
        exp_nop = 0; exp_issued = 0; cnt = 0; exp_err = 1'b0; inflight = 1'b0; drained = 1'b0;
        SYNC_RST = 1'b1;
        tick();
        SYNC_RST = 1'b0;
        tests++; if (fill_level !== 4'd0 || busy !== 1'b0 || instruction !== '0 || issued_cnt !== '0) begin fails++; $display("FAIL sync_reset: got fill=%0d busy=%b instr=%h iss=%0d want 0", fill_level, busy, instruction, issued_cnt); end
        EN = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            cu_done = 1'b0;
            if (instr_valid) begin
                tests++;
                if (inflight || exp_q.size() == 0 || instruction !== exp_q[0]) begin
                    fails++;
                    $display("FAIL rand_issue: got %h inflight=%b want %h", instruction, inflight, (exp_q.size() != 0) ? exp_q[0] : '0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                inflight = 1'b1;
                cnt = $urandom_range(4, 1);
            end else if (inflight) begin
                cnt--;
                if (cnt == 0) begin
                    cu_done = 1'b1;
                    inflight = 1'b0;
                    exp_issued++;
                end
            end
            if (cyc >= 400 && !busy && !inflight && !cu_done) begin
                drained = 1'b1;
                break;
            end
            push_valid = (cyc < 400) && ($urandom_range(2, 0) != 0);
            op = 3'($urandom_range(7, 0));
            d = {op, 26'($urandom)};
            push_data = d;
            if (push_valid && push_ready) begin
                if (op == 3'd0) exp_nop++;
                else if (op > 3'd5) exp_err = 1'b1;
                else exp_q.push_back(d);
            end
            tick();
        end
        push_valid = 1'b0;
        cu_done = 1'b0;
        tests++; if (!drained || exp_q.size() != 0) begin fails++; $display("FAIL rand_drain: got drained=%b left=%0d want 1/0", drained, exp_q.size()); end
        tests++; if (issued_cnt !== 16'(exp_issued) || nop_cnt !== 16'(exp_nop) || illegal_err !== exp_err) begin fails++; $display("FAIL rand_status: got iss=%0d nop=%0d err=%b want %0d/%0d/%b", issued_cnt, nop_cnt, illegal_err, exp_issued, exp_nop, exp_err); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_fill_wrap();
        test_drop();
        test_flush();
        test_async_reset();
        test_idle_done_full_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
